// File: rtl/id_decode_stage.sv
// RV32I/RV64I instruction decode stage; define RVCORE_MULDIV_EN to accept M-extension encodings.
// Latency: 1 cycle from accepted instruction to out_valid; sustains 1 instruction/cycle.
// Backpressure: main + skid register pair; in_ready is a flop (!skid valid), never combinational from out_ready.
module id_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rf_we,
    output logic [10:0]     out_alu_ctrl,
    output logic [6:0]      out_bru_ctrl,
    output logic [3:0]      out_store_ctrl,
    output logic [4:0]      out_load_ctrl,
    output logic [7:0]      out_muldiv_ctrl,
    output logic            out_illegal
);

    localparam bit IS64 = (XLEN == 64);
`ifdef RVCORE_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam int A_NEG = 0, A_ADD = 1, A_UNS = 2, A_CMP = 3, A_ARITH = 4, A_SLL = 5;
    localparam int A_SRL = 6, A_XOR = 7, A_AND = 8, A_JAL = 9, A_WORD = 10;

    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_MISC = 7'b0001111, OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_OPIMM32 = 7'b0011011, OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_LUI = 7'b0110111, OPC_OP32 = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            rf_we;
        logic [10:0]     alu;
        logic [6:0]      bru;
        logic [3:0]      st;
        logic [4:0]      ld;
        logic [7:0]      md;
        logic            illegal;
    } dec_t;

    // Compare ops are subtractions; OR is encoded as xor_or|or_and.
    function automatic logic [10:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [10:0] a;
        a = '0;
        case (f3)
            3'b000:  begin a[A_ADD] = 1'b1; a[A_NEG] = alt; end
            3'b001:  a[A_SLL] = 1'b1;
            3'b010:  begin a[A_CMP] = 1'b1; a[A_NEG] = 1'b1; end
            3'b011:  begin a[A_CMP] = 1'b1; a[A_NEG] = 1'b1; a[A_UNS] = 1'b1; end
            3'b100:  a[A_XOR] = 1'b1;
            3'b101:  begin a[A_SRL] = 1'b1; a[A_ARITH] = alt; end
            3'b110:  begin a[A_XOR] = 1'b1; a[A_AND] = 1'b1; end
            default: a[A_AND] = 1'b1;
        endcase
        return a;
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic        ill;
    dec_t        d;

    assign opc = in_ir[6:0];
    assign f3  = in_ir[14:12];
    assign f7  = in_ir[31:25];

    always_comb begin
        d       = '0;
        d.pc    = in_pc;
        d.rd    = in_ir[11:7];
        d.rs1   = in_ir[19:15];
        d.rs2   = in_ir[24:20];
        imm32   = {{20{in_ir[31]}}, in_ir[31:20]};
        ill     = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {in_ir[31:12], 12'b0};
                d.alu[A_ADD] = 1'b1;
                d.rf_we = 1'b1;
            end
            OPC_OPIMM: begin
                d.alu   = alu_op(f3, (f3 == 3'b101) && in_ir[30]);
                d.rf_we = 1'b1;
                if (!IS64 && (f3 == 3'b001 || f3 == 3'b101) && in_ir[25]) ill = 1'b1;
            end
            OPC_OPIMM32: begin
                if (!IS64 || !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ill = 1'b1;
                else begin
                    d.alu = alu_op(f3, (f3 == 3'b101) && in_ir[30]);
                    d.alu[A_WORD] = 1'b1;
                    d.rf_we = 1'b1;
                end
            end
            OPC_OP: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    d.alu   = alu_op(f3, f7[5] && (f3 == 3'b000 || f3 == 3'b101));
                    d.rf_we = 1'b1;
                end else if (MD_EN && f7 == 7'b0000001) begin
                    d.md    = 8'b1 << f3;
                    d.rf_we = 1'b1;
                end else ill = 1'b1;
            end
            OPC_OP32: begin
                if (!IS64) ill = 1'b1;
                else if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) begin
                        d.alu = alu_op(f3, f7[5]);
                        d.alu[A_WORD] = 1'b1;
                        d.rf_we = 1'b1;
                    end else ill = 1'b1;
                end else if (MD_EN && f7 == 7'b0000001) begin
                    if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
                    else begin
                        d.md    = 8'b1 << f3;
                        d.rf_we = 1'b1;
                    end
                end else ill = 1'b1;
            end
            OPC_LOAD: begin
                d.alu[A_ADD] = 1'b1;
                d.rf_we = 1'b1;
                case (f3)
                    3'b000:  d.ld = 5'b00011;
                    3'b001:  d.ld = 5'b00101;
                    3'b010:  d.ld = 5'b01001;
                    3'b011:  if (IS64) d.ld = 5'b10001; else ill = 1'b1;
                    3'b100:  d.ld = 5'b00010;
                    3'b101:  d.ld = 5'b00100;
                    3'b110:  if (IS64) d.ld = 5'b01000; else ill = 1'b1;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
                d.alu[A_ADD] = 1'b1;
                case (f3)
                    3'b000:  d.st = 4'b0001;
                    3'b001:  d.st = 4'b0010;
                    3'b010:  d.st = 4'b0100;
                    3'b011:  if (IS64) d.st = 4'b1000; else ill = 1'b1;
                    default: ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                imm32 = {{20{in_ir[31]}}, in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
                case (f3)
                    3'b000:  d.bru = 7'b0001000;
                    3'b001:  d.bru = 7'b0010000;
                    3'b100:  d.bru = 7'b0100001;
                    3'b101:  d.bru = 7'b1000001;
                    3'b110:  d.bru = 7'b0100000;
                    3'b111:  d.bru = 7'b1000000;
                    default: ill = 1'b1;
                endcase
            end
            OPC_JAL: begin
                imm32 = {{12{in_ir[31]}}, in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
                d.alu[A_JAL] = 1'b1;
                d.bru = 7'b0000100;
                d.rf_we = 1'b1;
            end
            OPC_JALR: begin
                d.alu[A_JAL] = 1'b1;
                d.bru = 7'b0000010;
                d.rf_we = 1'b1;
            end
            OPC_MISC, OPC_SYSTEM: ;
            default: ill = 1'b1;
        endcase
        d.imm = XLEN'($signed(imm32));
        if (ill) begin
            d.rf_we = 1'b0;
            d.alu   = '0;
            d.bru   = '0;
            d.st    = '0;
            d.ld    = '0;
            d.md    = '0;
        end
        if (d.rd == 5'd0) d.rf_we = 1'b0;
        d.illegal = ill;
    end

    logic m_vld, s_vld, acc, m_free;
    dec_t m, s;

    assign in_ready = !s_vld;
    assign acc      = in_valid && in_ready;
    assign m_free   = !m_vld || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (m_free) begin
            if (s_vld) begin
                m_vld <= 1'b1;
                s_vld <= 1'b0;
            end else m_vld <= acc;
        end else if (acc) s_vld <= 1'b1;
    end

    // Data regs only load on a real transfer so outputs hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m    <= '0;
            m.pc <= RESET_PC;
        end else if (!flush && m_free) begin
            if (s_vld) m <= s;
            else if (acc) m <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && !m_free && acc) s <= d;
    end

    assign out_valid       = m_vld;
    assign out_pc          = m.pc;
    assign out_rd          = m.rd;
    assign out_rs1         = m.rs1;
    assign out_rs2         = m.rs2;
    assign out_imm         = m.imm;
    assign out_rf_we       = m.rf_we;
    assign out_alu_ctrl    = m.alu;
    assign out_bru_ctrl    = m.bru;
    assign out_store_ctrl  = m.st;
    assign out_load_ctrl   = m.ld;
    assign out_muldiv_ctrl = m.md;
    assign out_illegal     = m.illegal;

endmodule
